// File: rtl/fp_round_norm.sv
// Normalize and round-to-nearest-even an extended FP mantissa into IEEE-754 single.
// Multi-cycle: one left shift per cycle, single operand in flight.
module fp_round_norm #(
   parameter int PRECISION = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_sign,
   input  logic [7:0]             in_exp,
   input  logic [24+PRECISION:0]  in_mant,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_result,
   output logic [2:0]             out_flags
);

   localparam int P  = PRECISION;
   localparam int MW = 25 + P;
   localparam int UW = MW - P;

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   state_t          state, state_n;
   logic            sign_q, sign_n;
   logic [8:0]      exp_q, exp_n;
   logic [MW-1:0]   mant_q, mant_n;
   logic [31:0]     res_q, res_n;
   logic [2:0]      flg_q, flg_n;

   logic            is_spec, is_zero;
   logic            guard, sticky, lsb, inc, inexact;
   logic [UW-1:0]   up;
   logic            hid;
   logic [22:0]     frac;
   logic [8:0]      exp_r;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         sign_q <= 1'b0;
         exp_q  <= '0;
         mant_q <= '0;
         res_q  <= '0;
         flg_q  <= '0;
      end else begin
         state  <= state_n;
         sign_q <= sign_n;
         exp_q  <= exp_n;
         mant_q <= mant_n;
         res_q  <= res_n;
         flg_q  <= flg_n;
      end
   end

   // Rounding works on the upper part only; the carry out lands in up[UW-1].
   always_comb begin
      guard   = mant_q[P-1];
      sticky  = |mant_q[P-2:0];
      lsb     = mant_q[P];
      inc     = guard && (sticky || lsb);
      inexact = |mant_q[P-1:0];
      up      = {1'b0, mant_q[MW-2:P]} + UW'(inc);
      hid     = up[UW-1] | up[UW-2];
      frac    = up[UW-1] ? up[UW-2:1] : up[UW-3:0];
      exp_r   = exp_q + {8'b0, up[UW-1]};
   end

   assign is_spec = (in_exp == 8'hFF);
   assign is_zero = !is_spec && (in_mant == '0);

   always_comb begin
      state_n = state;
      sign_n  = sign_q;
      exp_n   = exp_q;
      mant_n  = mant_q;
      res_n   = res_q;
      flg_n   = flg_q;
      case (state)
         IDLE: begin
            if (in_valid) begin
               sign_n = in_sign;
               exp_n  = {1'b0, (in_exp == 8'h00) ? 8'd1 : in_exp};
               mant_n = in_mant;
               unique case (1'b1)
                  is_spec: begin
                     res_n   = {in_sign, 8'hFF, in_mant[22+P:P]};
                     flg_n   = 3'b000;
                     state_n = DONE;
                  end
                  is_zero: begin
                     res_n   = {in_sign, 31'b0};
                     flg_n   = 3'b000;
                     state_n = DONE;
                  end
                  default: state_n = NORM;
               endcase
            end
         end
         NORM: begin
            unique case (1'b1)
               mant_q[MW-1]: begin
                  mant_n  = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
                  exp_n   = exp_q + 9'd1;
                  state_n = ROUND;
               end
               (!mant_q[MW-1] && !mant_q[MW-2] && exp_q > 9'd1): begin
                  mant_n = {mant_q[MW-2:0], 1'b0};
                  exp_n  = exp_q - 9'd1;
               end
               default: state_n = ROUND;
            endcase
         end
         ROUND: begin
            state_n = DONE;
            if (exp_r >= 9'd255) begin
               res_n = {sign_q, 8'hFF, 23'b0};
               flg_n = 3'b101;
            end else begin
               res_n = {sign_q, hid ? exp_r[7:0] : 8'h00, frac};
               flg_n = {1'b0, !hid && inexact, inexact};
            end
         end
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign out_result = res_q;
   assign out_flags  = flg_q;

endmodule

// File: tb/tb_fp_round_norm.sv
// Scoreboard bench for fp_round_norm: result, flags and latency per operand,
// plus stall, reset-abort and reset-priority scenarios.
module tb_fp_round_norm;

   localparam int P  = 3;
   localparam int MW = 25 + P;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic            in_sign;
   logic [7:0]      in_exp;
   logic [MW-1:0]   in_mant;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_result;
   logic [2:0]      out_flags;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  flg;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   fp_round_norm #(.PRECISION(P)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_exp     (in_exp),
      .in_mant    (in_mant),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   function automatic logic [MW-1:0] mk(input logic c, input logic h,
                                        input logic [22:0] f,
                                        input logic [2:0] g);
      return {c, h, f, g};
   endfunction

   // Called at a negedge; leaves at the negedge after the accept edge.
   task automatic drive(input logic s, input logic [7:0] e,
                        input logic [MW-1:0] m, input int lat,
                        input logic [31:0] r, input logic [2:0] f,
                        input bit push);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("ready_timeout", 32'd0, 32'd1);
         return;
      end
      if (push) sb.push_back('{res: r, flg: f, cyc: cyc + lat});
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = e;
      in_mant  = m;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", out_result, e.res);
            check("flags", {29'b0, out_flags}, {29'b0, e.flg});
            check("latency", cyc, e.cyc);
         end
      end
   end

   initial begin
      int n;
      bit seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      in_mant   = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_ready", {31'b0, in_ready}, 32'd1);
      check("rst_result", out_result, 32'd0);
      check("rst_flags", {29'b0, out_flags}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      drive(0, 8'h7F, mk(0, 1, 23'h0, 3'b000), 3, 32'h3F800000, 3'b000, 1);
      drive(0, 8'h7F, mk(1, 1, 23'h0, 3'b000), 3, 32'h40400000, 3'b000, 1);
      drive(0, 8'h80, mk(0, 0, 23'h200000, 3'b000), 5, 32'h3F000000, 3'b000, 1);
      drive(0, 8'h7F, mk(0, 1, 23'h000001, 3'b100), 3, 32'h3F800002, 3'b001, 1);
      drive(0, 8'h7F, mk(0, 1, 23'h0, 3'b100), 3, 32'h3F800000, 3'b001, 1);
      drive(0, 8'hFE, mk(0, 1, 23'h7FFFFF, 3'b100), 3, 32'h7F800000, 3'b101, 1);
      drive(0, 8'h01, mk(0, 0, 23'h000001, 3'b010), 3, 32'h00000001, 3'b011, 1);
      drive(1, 8'h55, '0, 1, 32'h80000000, 3'b000, 1);
      drive(0, 8'hFF, mk(1, 1, 23'h400000, 3'b111), 1, 32'h7FC00000, 3'b000, 1);
      drive(0, 8'h00, mk(0, 1, 23'h0, 3'b000), 3, 32'h00800000, 3'b000, 1);
      drive(0, 8'h7F, mk(0, 1, 23'h7FFFFF, 3'b110), 3, 32'h40000000, 3'b001, 1);
      drive(0, 8'h7F, mk(0, 1, 23'h000002, 3'b011), 3, 32'h3F800002, 3'b001, 1);
      drive(0, 8'hFE, mk(1, 1, 23'h0, 3'b000), 3, 32'h7F800000, 3'b101, 1);
      drive(0, 8'h01, mk(0, 0, 23'h7FFFFF, 3'b100), 3, 32'h00800000, 3'b001, 1);
      drive(1, 8'h7F, mk(0, 1, 23'h0, 3'b000), 3, 32'hBF800000, 3'b000, 1);
      drive(0, 8'h03, mk(0, 0, 23'h000004, 3'b000), 5, 32'h00000010, 3'b000, 1);
      drive(0, 8'h7F, mk(1, 1, 23'h0, 3'b001), 3, 32'h40400000, 3'b001, 1);

      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 32'd0);

      // Reset wins over a simultaneous in_valid.
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_exp   = 8'h7F;
      in_mant  = mk(0, 1, 23'h0, 3'b000);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      check("rst_prio_ready", {31'b0, in_ready}, 32'd1);
      check("rst_prio_valid", {31'b0, out_valid}, 32'd0);

      // Reset mid-operation aborts with no output.
      drive(0, 8'h80, mk(0, 0, 23'h000010, 3'b000), 0, 32'h0, 3'b000, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (25) begin
         @(negedge clk);
         seen |= out_valid;
      end
      check("abort_no_out", {31'b0, seen}, 32'd0);

      // Stall in DONE, then reset.
      out_ready = 1'b0;
      drive(0, 8'h7F, mk(0, 1, 23'h0, 3'b000), 0, 32'h0, 3'b000, 0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      repeat (5) begin
         @(negedge clk);
         check("stall_result", out_result, 32'h3F800000);
         check("stall_ready", {31'b0, in_ready}, 32'd0);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("stall_rst_valid", {31'b0, out_valid}, 32'd0);
      check("stall_rst_ready", {31'b0, in_ready}, 32'd1);
      check("stall_rst_result", out_result, 32'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("final_queue", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
